// File: rtl/win_score_counter.sv
// Tug-of-war win score counter: counts one player's wins, drives a 7-seg digit,
// pulses round_reset after each non-final win and latches game_over at MAX_SCORE.
// Latency: outputs update right after the edge that samples a win rising edge; no backpressure.
module win_score_counter #(
  parameter int WIDTH          = 3,
  parameter int MAX_SCORE      = 7,
  parameter int RESTART_CYCLES = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             win,
  output logic [WIDTH-1:0] score,
  output logic [6:0]       HEX,
  output logic             round_reset,
  output logic             game_over
);

  localparam int CW = $clog2(RESTART_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(RESTART_CYCLES - 1);
  localparam logic [WIDTH-1:0] SCORE_MAX = WIDTH'(MAX_SCORE);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    RESTART = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] score_q, score_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             win_q, win_d;
  logic             round_reset_q, round_reset_d;
  logic             game_over_q, game_over_d;

  logic             win_event;
  logic [WIDTH-1:0] score_inc;
  logic [31:0]      score_ext;

  assign win_event = win & ~win_q;
  assign score_inc = score_q + WIDTH'(1);

  // Next-state logic: count a win only in PLAY, then either restart the round or end the game.
  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    cnt_d         = cnt_q;
    win_d         = win;
    round_reset_d = round_reset_q;
    game_over_d   = game_over_q;
    case (state_q)
      PLAY: begin
        round_reset_d = 1'b0;
        if (win_event) begin
          score_d       = score_inc;
          round_reset_d = 1'b1;
          if (score_inc == SCORE_MAX) begin
            state_d     = DONE;
            game_over_d = 1'b1;
          end else begin
            state_d = RESTART;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      RESTART: begin
        // Wins are ignored here, including one arriving on the edge the counter expires.
        if (cnt_q == '0) begin
          state_d       = PLAY;
          round_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        round_reset_d = 1'b1;
        game_over_d   = 1'b1;
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // State registers; win_q resets high so a win level held through reset is not counted.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= PLAY;
      score_q       <= '0;
      cnt_q         <= '0;
      win_q         <= 1'b1;
      round_reset_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      cnt_q         <= cnt_d;
      win_q         <= win_d;
      round_reset_q <= round_reset_d;
      game_over_q   <= game_over_d;
    end
  end

  assign score_ext = 32'(score_q);

  // Active-low {g,f,e,d,c,b,a} digit decode; out-of-range values blank the display.
  always_comb begin
    HEX = 7'b1111111;
    case (score_ext)
      32'd0:   HEX = 7'b1000000;
      32'd1:   HEX = 7'b1111001;
      32'd2:   HEX = 7'b0100100;
      32'd3:   HEX = 7'b0110000;
      32'd4:   HEX = 7'b0011001;
      32'd5:   HEX = 7'b0010010;
      32'd6:   HEX = 7'b0000010;
      32'd7:   HEX = 7'b1111000;
      32'd8:   HEX = 7'b0000000;
      32'd9:   HEX = 7'b0010000;
      default: HEX = 7'b1111111;
    endcase
  end

  assign score       = score_q;
  assign round_reset = round_reset_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_win_score_counter.sv
// Bench for win_score_counter: directed win patterns, a cycle-level reference model
// compared every negedge, and literal expectations at the key points of each scenario.
module tb_win_score_counter;

  localparam int WIDTH = 3;
  localparam int MAXS  = 7;
  localparam int RC    = 4;

  logic             clk   = 1'b0;
  logic             Reset = 1'b0;
  logic             win   = 1'b0;
  logic [WIDTH-1:0] score;
  logic [6:0]       HEX;
  logic             round_reset;
  logic             game_over;

  int vectors     = 0;
  int miscompares = 0;

  win_score_counter #(
    .WIDTH(WIDTH),
    .MAX_SCORE(MAXS),
    .RESTART_CYCLES(RC)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .win(win),
    .score(score),
    .HEX(HEX),
    .round_reset(round_reset),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Display table straight from the digit definitions.
  logic [6:0] hex_tab [0:15];
  initial begin
    for (int i = 0; i < 16; i++) hex_tab[i] = 7'b1111111;
    hex_tab[0] = 7'b1000000; hex_tab[1] = 7'b1111001; hex_tab[2] = 7'b0100100;
    hex_tab[3] = 7'b0110000; hex_tab[4] = 7'b0011001; hex_tab[5] = 7'b0010010;
    hex_tab[6] = 7'b0000010; hex_tab[7] = 7'b1111000; hex_tab[8] = 7'b0000000;
    hex_tab[9] = 7'b0010000;
  end

  // Reference model: a win counts if win rose, the game is not over, and the
  // edge is strictly past the restart window of the last counted win.
  int m_score    = 0;
  int m_prev     = 1;
  int m_done     = 0;
  int m_has_last = 0;
  int m_last     = 0;
  int cyc        = 0;

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m_score    = 0;
      m_prev     = 1;
      m_done     = 0;
      m_has_last = 0;
    end else begin
      cyc = cyc + 1;
      if (win && m_prev == 0 && m_done == 0 &&
          (m_has_last == 0 || cyc > m_last + RC)) begin
        m_score    = m_score + 1;
        m_last     = cyc;
        m_has_last = 1;
        if (m_score == MAXS) m_done = 1;
      end
      m_prev = win ? 1 : 0;
    end
  end

  function automatic int exp_rr();
    return (m_done != 0 || (m_has_last != 0 && cyc < m_last + RC)) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_score", int'(score), m_score);
    chk("model_hex", int'(HEX), int'(hex_tab[m_score]));
    chk("model_round_reset", int'(round_reset), exp_rr());
    chk("model_game_over", int'(game_over), m_done);
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    win = 1'b1;
    @(negedge clk);
    win = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_hex"}, int'(HEX), int'(7'b1000000));
    chk({tag, "_rr"}, int'(round_reset), 0);
    chk({tag, "_go"}, int'(game_over), 0);
  endtask

  int cnt;

  initial begin
    #1 Reset = 1'b1;
    win = 1'b0;
    // Reset held 5 cycles
    gap(5);
    chk_reset_vals("reset");
    Reset = 1'b0;
    gap(3);
    chk_reset_vals("post_reset");

    // Single one-cycle win
    pulse();
    chk("single_score", int'(score), 1);
    chk("single_hex", int'(HEX), int'(7'b1111001));
    cnt = round_reset ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (round_reset) cnt++;
    end
    chk("single_rr_len", cnt, 4);

    // Win held high for 10 cycles counts once, one pulse only
    win = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (round_reset) cnt++;
    end
    win = 1'b0;
    gap(2);
    chk("held_rr_len", cnt, 4);
    chk("held_score", int'(score), 2);
    chk("held_rr_low", int'(round_reset), 0);

    // Win during restart ignored; win on the counter-expiry edge ignored
    pulse();                       // counted at edge N
    chk("restart_first", int'(score), 3);
    gap(1);
    pulse();                       // edge N+2, inside restart
    chk("restart_ignore", int'(score), 3);
    gap(1);
    win = 1'b1;                    // sampled on edge N+4
    @(negedge clk);
    chk("expiry_edge_score", int'(score), 3);
    chk("expiry_edge_rr", int'(round_reset), 0);
    @(negedge clk);                // still high in PLAY: no event
    chk("held_into_play", int'(score), 3);
    win = 1'b0;
    @(negedge clk);
    pulse();                       // low then high again: counted
    chk("after_restart", int'(score), 4);

    // Run to game over
    for (int k = 5; k <= MAXS; k++) begin
      gap(6);
      pulse();
      chk("ramp_score", int'(score), k);
    end
    chk("over_hex", int'(HEX), int'(7'b1111000));
    chk("over_go", int'(game_over), 1);
    chk("over_rr", int'(round_reset), 1);
    gap(6);
    pulse();
    gap(3);
    chk("over_extra_score", int'(score), 7);
    chk("over_extra_go", int'(game_over), 1);
    chk("over_extra_rr", int'(round_reset), 1);

    // Asynchronous reset in DONE, with win held across the release
    @(posedge clk);
    #2 Reset = 1'b1;
    #1 chk_reset_vals("async_done");
    win = 1'b1;
    gap(2);
    Reset = 1'b0;
    gap(3);
    chk("held_release_score", int'(score), 0);
    chk("held_release_rr", int'(round_reset), 0);
    win = 1'b0;

    // Asynchronous reset two cycles into a restart
    gap(1);
    pulse();
    chk("mid_restart_score", int'(score), 1);
    gap(1);
    @(posedge clk);
    #2 Reset = 1'b1;
    #1 chk_reset_vals("async_restart");
    @(negedge clk);
    Reset = 1'b0;
    gap(6);
    chk("no_pending_rr", int'(round_reset), 0);
    chk("no_pending_score", int'(score), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/win_score_counter.md
# win_score_counter

Downstream of the last light stage of the tug-of-war light chain. Consumes the last stage's `Out` (player win) level, counts wins for one player, and drives an active-low 7-segment score digit. After each counted win it issues a timed `round_reset` back to the light chain to start a new round. On reaching the winning score it latches game over.

## Interface
Parameters:
- `WIDTH`, 3: score register width in bits.
- `MAX_SCORE`, 7: score that ends the game. Legal range 1..9 and ≤ 2^WIDTH−1.
- `RESTART_CYCLES`, 4: cycles `round_reset` stays high after a non-final win. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `win`  in  1  `Out` of the last light stage. Level signal, synchronous to `clk`.
- `score`  out  WIDTH  current win count, registered.
- `HEX`  out  7  active-low segments {g,f,e,d,c,b,a}, decoded from `score`.
- `round_reset`  out  1  registered; high requests reset of the light chain.
- `game_over`  out  1  registered; high once `MAX_SCORE` is reached.

## Operation
- Edge detect:
  - `win_q` is a registered copy of `win`, updated every cycle in every state.
  - A win event is `win & ~win_q`.
  - `win_q` resets to 1, so a `win` level held through reset release is not counted.
- States: `PLAY`, `RESTART`, `DONE`. Reset state is `PLAY`.
- `PLAY`, on a win event:
  - `score <= score + 1`.
  - If `score + 1 == MAX_SCORE`: go to `DONE` and assert `game_over` and `round_reset`.
  - Else: go to `RESTART`, assert `round_reset`, load the restart counter with `RESTART_CYCLES−1`.
- `PLAY`, with no event: hold state, `round_reset` = 0.
- `RESTART`:
  - Win events are ignored and `score` is held.
  - The counter decrements each cycle.
  - When the counter is 0: return to `PLAY` and deassert `round_reset`.
- `DONE`:
  - Terminal state. `score` holds at `MAX_SCORE`.
  - `game_over` = 1 and `round_reset` = 1.
  - All `win` activity is ignored. Only `Reset` exits.
- Arithmetic: increments are unsigned WIDTH-bit. `score` never exceeds `MAX_SCORE`, so it never wraps.
- `HEX` decode (combinational from `score`):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other value = 1111111 (blank).
- Restart counter width is $clog2(RESTART_CYCLES)+1 bits.

## Timing
- Reset values, applied immediately on `Reset` assertion independent of `clk`:
  - `score`=0, `HEX`=1000000, `round_reset`=0, `game_over`=0.
  - State `PLAY`, `win_q`=1, counter=0.
- Reset asserted mid-`RESTART` or in `DONE` aborts immediately to the values above. No pending restart pulse survives.
- Win event latency: if `win` first samples 1 at edge N (and `win_q` was 0), then `score`, `HEX` and `round_reset` change right after edge N.
- Non-final win: `round_reset` is high for exactly `RESTART_CYCLES` cycles, from after edge N through edge N+`RESTART_CYCLES`, then low.
- First cycle back in `PLAY` (after edge N+`RESTART_CYCLES`):
  - `win` still high: `win_q` is also high, so no event.
  - `win` low then high again: a new event is counted.
- Final win at edge N: `game_over` and `round_reset` rise after edge N and stay high until `Reset`.
- `win` rising on the same edge the restart counter hits 0 is ignored. The state at that edge is `RESTART`.

## Test plan
- Reset: assert `Reset` for 5 cycles with `win`=0 → `score`=0, `HEX`=1000000, `round_reset`=0, `game_over`=0; all hold after release.
- Single win: `win` 0→1 for 1 cycle → `score`=1, `HEX`=1111001 after that edge; `round_reset` high exactly 4 cycles, then 0.
- Held win: `win` high for 10 cycles → `score` increments once to 1; no second `round_reset` pulse.
- Win during restart: second rising edge of `win` 2 cycles after the first → ignored; `score`=1. Third rising edge after return to `PLAY` → `score`=2.
- Game over: 7 separated win pulses → `score`=7, `HEX`=1111000, `game_over`=1, `round_reset`=1 held. An 8th pulse leaves `score`=7.
- Reset mid-operation: `Reset` asserted asynchronously 2 cycles into a restart, and again in `DONE` → outputs return to reset values immediately, before the next `clk` edge. A `win` held high across reset release is not counted.
